multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/mips_ctrl_pkg.sv | 67 ++++++
 rtl/multicycle_control_if.sv | 43 ++++
 rtl/multicycle_ctrl_outdec.sv | 93 +++++++++
 rtl/multicycle_control.sv | 99 +++++++++
 tb/tb_multicycle_control.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, select codes,
// FSM state encodings and the packed strobe bundle driven by the output decoder.
package mips_ctrl_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned SEL_W   = 2;

    // Supported opcodes
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    // ALU operation class
    localparam logic [SEL_W-1:0] ALUOP_RTYPE = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b10;

    // ALU operand B select
    localparam logic [SEL_W-1:0] SRCB_REG     = 2'd0;
    localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'd1;
    localparam logic [SEL_W-1:0] SRCB_IMM     = 2'd2;
    localparam logic [SEL_W-1:0] SRCB_IMM_SH2 = 2'd3;

    // Next-PC source select
    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'd0;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'd2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    // Datapath strobes and selects produced from the current state
    typedef struct packed {
        logic             pc_write;
        logic             pc_write_cond;
        logic             iord;
        logic             mem_read;
        logic             mem_write;
        logic             ir_write;
        logic             mem_to_reg;
        logic             reg_dst;
        logic             reg_write;
        logic             alu_src_a;
        logic             ext_op;
        logic [SEL_W-1:0] alu_src_b;
        logic [SEL_W-1:0] alu_op;
        logic [SEL_W-1:0] pc_source;
        logic             instr_done;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath signal bundle; the controller is the master side.
interface multicycle_control_if;

    logic [mips_ctrl_pkg::OP_W-1:0]    Op_i;
    logic                              mem_ready_i;

    logic                              PCWrite_o;
    logic                              PCWriteCond_o;
    logic                              IorD_o;
    logic                              MemRead_o;
    logic                              MemWrite_o;
    logic                              IRWrite_o;
    logic                              MemtoReg_o;
    logic                              RegDst_o;
    logic                              RegWrite_o;
    logic                              ALUSrcA_o;
    logic                              ExtOp_o;
    logic [mips_ctrl_pkg::SEL_W-1:0]   ALUSrcB_o;
    logic [mips_ctrl_pkg::SEL_W-1:0]   ALUOp_o;
    logic [mips_ctrl_pkg::SEL_W-1:0]   PCSource_o;
    logic                              instr_done_o;
    logic                              illegal_o;
    logic [mips_ctrl_pkg::STATE_W-1:0] state_o;

    // Controller view
    modport master (
        input  Op_i, mem_ready_i,
        output PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o,
               IRWrite_o, MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o,
               ExtOp_o, ALUSrcB_o, ALUOp_o, PCSource_o, instr_done_o,
               illegal_o, state_o
    );

    // Datapath / memory view
    modport slave (
        output Op_i, mem_ready_i,
        input  PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o,
               IRWrite_o, MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o,
               ExtOp_o, ALUSrcB_o, ALUOp_o, PCSource_o, instr_done_o,
               illegal_o, state_o
    );

endinterface

// File: rtl/multicycle_ctrl_outdec.sv
// Moore output decoder: maps the current state (and memory-ready for the
// cycles that complete an access) onto the datapath strobes.
module multicycle_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t state_i,
    input  logic   mem_ready_i,
    output ctrl_t  ctrl_o
);

    // Strobe table; anything not set for a state stays 0
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.iord      = 1'b0;
                ctrl_o.alu_src_a = 1'b0;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                // IR and PC commit only on the cycle the instruction word arrives
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_a = 1'b0;
                ctrl_o.alu_src_b = SRCB_IMM_SH2;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.ext_op    = 1'b1;
            end
            S_MEMADR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.ext_op    = 1'b1;
            end
            S_MEMRD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.reg_dst    = 1'b0;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.iord       = 1'b1;
                ctrl_o.instr_done = mem_ready_i;
            end
            S_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REG;
                ctrl_o.alu_op    = ALUOP_RTYPE;
            end
            S_RWB: begin
                ctrl_o.reg_dst    = 1'b1;
                ctrl_o.mem_to_reg = 1'b0;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_REG;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
                ctrl_o.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_source  = PCSRC_JUMP;
                ctrl_o.instr_done = 1'b1;
            end
            S_ADDIEX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.ext_op    = 1'b0;
            end
            S_ADDIWB: begin
                ctrl_o.reg_dst    = 1'b0;
                ctrl_o.mem_to_reg = 1'b0;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main controller: state register, next-state logic and the
// opcode latch; strobe decode lives in multicycle_ctrl_outdec.
module multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    multicycle_control_if.master bus
);

    state_t            state_q;
    state_t            state_d;
    logic [OP_W-1:0]   op_q;
    logic [OP_W-1:0]   op_d;
    logic              ready_c;
    logic              illegal_c;
    ctrl_t             ctrl_c;

    // Reset masks memory-ready so IRWrite/PCWrite stay low while held in FETCH
    assign ready_c = bus.mem_ready_i & rst_i;

    // State register and DECODE-time opcode latch
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Next-state selection; opcode is only looked at in DECODE
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        illegal_c = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (ready_c) state_d = S_DECODE;
            end
            S_DECODE: begin
                op_d = bus.Op_i;
                case (bus.Op_i)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_c = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                if (op_q == OP_SW)      state_d = S_MEMWR;
                else if (op_q == OP_LW) state_d = S_MEMRD;
                else                    state_d = S_FETCH;
            end
            S_MEMRD: begin
                if (ready_c) state_d = S_MEMWB;
            end
            S_MEMWR: begin
                if (ready_c) state_d = S_FETCH;
            end
            S_EXEC:   state_d = S_RWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_RWB, S_ADDIWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    multicycle_ctrl_outdec u_outdec (
        .state_i     (state_q),
        .mem_ready_i (ready_c),
        .ctrl_o      (ctrl_c)
    );

    // Fan the strobe bundle out onto the interface
    assign bus.PCWrite_o     = ctrl_c.pc_write;
    assign bus.PCWriteCond_o = ctrl_c.pc_write_cond;
    assign bus.IorD_o        = ctrl_c.iord;
    assign bus.MemRead_o     = ctrl_c.mem_read;
    assign bus.MemWrite_o    = ctrl_c.mem_write;
    assign bus.IRWrite_o     = ctrl_c.ir_write;
    assign bus.MemtoReg_o    = ctrl_c.mem_to_reg;
    assign bus.RegDst_o      = ctrl_c.reg_dst;
    assign bus.RegWrite_o    = ctrl_c.reg_write;
    assign bus.ALUSrcA_o     = ctrl_c.alu_src_a;
    assign bus.ExtOp_o       = ctrl_c.ext_op;
    assign bus.ALUSrcB_o     = ctrl_c.alu_src_b;
    assign bus.ALUOp_o       = ctrl_c.alu_op;
    assign bus.PCSource_o    = ctrl_c.pc_source;
    assign bus.instr_done_o  = ctrl_c.instr_done;
    assign bus.illegal_o     = illegal_c;
    assign bus.state_o       = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Scenario bench for multicycle_control: expected state/strobe words are
// queued when each cycle's inputs are driven and checked mid-cycle.
module tb_multicycle_control;

    typedef struct packed {
        logic [3:0]  st;
        logic [18:0] v;
    } exp_t;

    // FETCH strobes with IRWrite/PCWrite low: the value held during reset
    localparam logic [18:0] RESET_VEC = 19'b0_0_0_1_0_0_0_0_0_0_0_01_01_00_0_0;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    exp_t sb_q[$];

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe word expected for a state, written from the controller's state table
    function automatic logic [18:0] spec_out(int unsigned st, bit rdy, bit ill);
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, sa, ext, done;
        logic [1:0] srcb, aop, pcs;
        {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, sa, ext, done} = '0;
        srcb = 2'd0; aop = 2'd0; pcs = 2'd0;
        case (st)
            0:  begin mr = 1; srcb = 2'd1; aop = 2'b01; irw = rdy; pcw = rdy; end
            1:  begin srcb = 2'd3; aop = 2'b01; ext = 1; end
            2:  begin sa = 1; srcb = 2'd2; aop = 2'b01; ext = 1; end
            3:  begin mr = 1; iord = 1; end
            4:  begin m2r = 1; rw = 1; done = 1; end
            5:  begin mw = 1; iord = 1; done = rdy; end
            6:  begin sa = 1; srcb = 2'd0; aop = 2'b00; end
            7:  begin rdst = 1; rw = 1; done = 1; end
            8:  begin sa = 1; aop = 2'b10; pcwc = 1; pcs = 2'd1; done = 1; end
            9:  begin pcw = 1; pcs = 2'd2; done = 1; end
            10: begin sa = 1; srcb = 2'd2; aop = 2'b01; end
            11: begin rw = 1; done = 1; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, sa, ext, srcb, aop, pcs, done, ill};
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o.st = bus.state_o;
        o.v  = {bus.PCWrite_o, bus.PCWriteCond_o, bus.IorD_o, bus.MemRead_o,
                bus.MemWrite_o, bus.IRWrite_o, bus.MemtoReg_o, bus.RegDst_o,
                bus.RegWrite_o, bus.ALUSrcA_o, bus.ExtOp_o, bus.ALUSrcB_o,
                bus.ALUOp_o, bus.PCSource_o, bus.instr_done_o, bus.illegal_o};
        return o;
    endfunction

    task automatic drive_push(logic [5:0] op, bit rdy, int unsigned st, bit ill);
        exp_t e;
        bus.Op_i        = op;
        bus.mem_ready_i = rdy;
        e.st = 4'(st);
        e.v  = spec_out(st, rdy, ill);
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e, got;
        #2;
        sb_q.push_back('{st: 4'd0, v: RESET_VEC});
        e = sb_q.pop_front(); got = observed(); n_vec++;
        if (got !== e) begin
            n_err++;
            $display("FAIL reset_early: got st=%0d v=%b want st=%0d v=%b", got.st, got.v, e.st, e.v);
        end
        bus.mem_ready_i = 1'b1;
        @(negedge clk);
        sb_q.push_back('{st: 4'd0, v: RESET_VEC});
        e = sb_q.pop_front(); got = observed(); n_vec++;
        if (got !== e) begin
            n_err++;
            $display("FAIL reset_ready_gated: got st=%0d v=%b want st=%0d v=%b", got.st, got.v, e.st, e.v);
        end
        @(posedge clk); #1;
        sb_q.push_back('{st: 4'd0, v: RESET_VEC});
        e = sb_q.pop_front(); got = observed(); n_vec++;
        if (got !== e) begin
            n_err++;
            $display("FAIL reset_hold_edge: got st=%0d v=%b want st=%0d v=%b", got.st, got.v, e.st, e.v);
        end
        bus.mem_ready_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_rtype();
        logic [5:0]  ops [5] = '{6'h3f, 6'h3f, 6'b000000, 6'h3f, 6'h3f};
        bit          rdy [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        int unsigned sts [5] = '{0, 0, 1, 6, 7};
        exp_t e, got;
        for (int i = 0; i < 5; i++) begin
            drive_push(ops[i], rdy[i], sts[i], 1'b0);
            @(negedge clk);
            e = sb_q.pop_front(); got = observed(); n_vec++;
            if (got !== e) begin
                n_err++;
                $display("FAIL rtype cyc%0d: got st=%0d v=%b want st=%0d v=%b", i, got.st, got.v, e.st, e.v);
            end
            @(posedge clk); #1;
        end
    endtask

    // Op_i switched to sw after DECODE must not divert the lw
    task automatic test_lw_wait();
        logic [5:0]  ops [7] = '{6'h3f, 6'b100011, 6'b101011, 6'b101011, 6'b101011, 6'b101011, 6'b101011};
        bit          rdy [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int unsigned sts [7] = '{0, 1, 2, 3, 3, 3, 4};
        exp_t e, got;
        for (int i = 0; i < 7; i++) begin
            drive_push(ops[i], rdy[i], sts[i], 1'b0);
            @(negedge clk);
            e = sb_q.pop_front(); got = observed(); n_vec++;
            if (got !== e) begin
                n_err++;
                $display("FAIL lw_wait cyc%0d: got st=%0d v=%b want st=%0d v=%b", i, got.st, got.v, e.st, e.v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw();
        logic [5:0]  ops [6] = '{6'h00, 6'b101011, 6'b100011, 6'h00, 6'h00, 6'h00};
        bit          rdy [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        int unsigned sts [6] = '{0, 1, 2, 5, 5, 0};
        exp_t e, got;
        for (int i = 0; i < 6; i++) begin
            drive_push(ops[i], rdy[i], sts[i], 1'b0);
            @(negedge clk);
            e = sb_q.pop_front(); got = observed(); n_vec++;
            if (got !== e) begin
                n_err++;
                $display("FAIL sw cyc%0d: got st=%0d v=%b want st=%0d v=%b", i, got.st, got.v, e.st, e.v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_addi();
        logic [5:0]  ops [5] = '{6'h3f, 6'b001000, 6'h00, 6'h00, 6'h00};
        bit          rdy [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int unsigned sts [5] = '{0, 1, 10, 11, 0};
        exp_t e, got;
        for (int i = 0; i < 5; i++) begin
            drive_push(ops[i], rdy[i], sts[i], 1'b0);
            @(negedge clk);
            e = sb_q.pop_front(); got = observed(); n_vec++;
            if (got !== e) begin
                n_err++;
                $display("FAIL addi cyc%0d: got st=%0d v=%b want st=%0d v=%b", i, got.st, got.v, e.st, e.v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_jump();
        logic [5:0]  ops [6] = '{6'h3f, 6'b000100, 6'h3f, 6'h3f, 6'b000010, 6'h3f};
        bit          rdy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        int unsigned sts [6] = '{0, 1, 8, 0, 1, 9};
        exp_t e, got;
        for (int i = 0; i < 6; i++) begin
            drive_push(ops[i], rdy[i], sts[i], 1'b0);
            @(negedge clk);
            e = sb_q.pop_front(); got = observed(); n_vec++;
            if (got !== e) begin
                n_err++;
                $display("FAIL branch_jump cyc%0d: got st=%0d v=%b want st=%0d v=%b", i, got.st, got.v, e.st, e.v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        logic [5:0]  ops [5] = '{6'h00, 6'b111111, 6'h00, 6'b000001, 6'h00};
        bit          rdy [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int unsigned sts [5] = '{0, 1, 0, 1, 0};
        bit          ill [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        exp_t e, got;
        for (int i = 0; i < 5; i++) begin
            drive_push(ops[i], rdy[i], sts[i], ill[i]);
            @(negedge clk);
            e = sb_q.pop_front(); got = observed(); n_vec++;
            if (got !== e) begin
                n_err++;
                $display("FAIL illegal cyc%0d: got st=%0d v=%b want st=%0d v=%b", i, got.st, got.v, e.st, e.v);
            end
            @(posedge clk); #1;
        end
    endtask

    // R-type, j, beq, addi with zero memory wait
    task automatic test_back_to_back();
        logic [5:0]  ops [14] = '{6'h3f, 6'b000000, 6'h3f, 6'h3f,
                                  6'h3f, 6'b000010, 6'h3f,
                                  6'h3f, 6'b000100, 6'h3f,
                                  6'h3f, 6'b001000, 6'h3f, 6'h3f};
        int unsigned sts [14] = '{0, 1, 6, 7, 0, 1, 9, 0, 1, 8, 0, 1, 10, 11};
        exp_t e, got;
        for (int i = 0; i < 14; i++) begin
            drive_push(ops[i], 1'b1, sts[i], 1'b0);
            @(negedge clk);
            e = sb_q.pop_front(); got = observed(); n_vec++;
            if (got !== e) begin
                n_err++;
                $display("FAIL back_to_back cyc%0d: got st=%0d v=%b want st=%0d v=%b", i, got.st, got.v, e.st, e.v);
            end
            @(posedge clk); #1;
        end
    endtask

    // Reset dropped between edges while a load waits in MEMRD
    task automatic test_async_reset();
        logic [5:0]  ops [4] = '{6'h3f, 6'b100011, 6'h3f, 6'h3f};
        bit          rdy [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        int unsigned sts [4] = '{0, 1, 2, 3};
        logic [5:0]  ops2 [4] = '{6'h3f, 6'h3f, 6'b000010, 6'h3f};
        bit          rdy2 [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        int unsigned sts2 [4] = '{0, 0, 1, 9};
        exp_t e, got;
        for (int i = 0; i < 4; i++) begin
            drive_push(ops[i], rdy[i], sts[i], 1'b0);
            @(negedge clk);
            e = sb_q.pop_front(); got = observed(); n_vec++;
            if (got !== e) begin
                n_err++;
                $display("FAIL async_pre cyc%0d: got st=%0d v=%b want st=%0d v=%b", i, got.st, got.v, e.st, e.v);
            end
            @(posedge clk); #1;
        end
        bus.mem_ready_i = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        sb_q.push_back('{st: 4'd0, v: RESET_VEC});
        e = sb_q.pop_front(); got = observed(); n_vec++;
        if (got !== e || bus.MemWrite_o !== 1'b0) begin
            n_err++;
            $display("FAIL async_abort: got st=%0d v=%b want st=%0d v=%b", got.st, got.v, e.st, e.v);
        end
        bus.mem_ready_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            drive_push(ops2[i], rdy2[i], sts2[i], 1'b0);
            @(negedge clk);
            e = sb_q.pop_front(); got = observed(); n_vec++;
            if (got !== e) begin
                n_err++;
                $display("FAIL async_post cyc%0d: got st=%0d v=%b want st=%0d v=%b", i, got.st, got.v, e.st, e.v);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.Op_i = 6'd0;
        bus.mem_ready_i = 1'b0;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_sw();
        test_addi();
        test_branch_jump();
        test_illegal();
        test_back_to_back();
        test_async_reset();
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish by 50000, want finish earlier");
        $fatal(1);
    end

endmodule
